// File: rtl/sdram_arb_pkg.sv
// Shared types and address layout for the SDRAM frame arbiter.
// SDRAM word address is {bank[1:0], row[12:0], col[8:0]}; bank[0] selects the ping-pong buffer.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRefresh,
        StWrCmd,
        StWrData,
        StRdCmd,
        StRdData
    } state_e;

    localparam int unsigned BankWidth   = 2;
    localparam int unsigned RowWidth    = 13;
    localparam int unsigned ColWidth    = 9;
    localparam int unsigned OffsetWidth = RowWidth + ColWidth;
    localparam int unsigned AddrWidth   = BankWidth + OffsetWidth;

    localparam int unsigned DefaultFrameWords = 640 * 480;

    localparam logic BufIdx0 = 1'b0;
    localparam logic BufIdx1 = 1'b1;

    // The linear offset splits naturally into row (upper) and column (lower) bits.
    function automatic logic [AddrWidth-1:0] make_addr(input logic bank_sel,
                                                       input logic [OffsetWidth-1:0] offset);
        return {1'b0, bank_sel, offset};
    endfunction

endpackage

// File: rtl/sdram_frame_arbiter_if.sv
// Requester-side and SDRAM-controller-side signals of the frame arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sdram_frame_arbiter_if #(
    parameter int unsigned PixelBitWidth     = 16,
    parameter int unsigned AddressWidthSDRAM = 24
);

    logic                         i_wr_req;
    logic                         i_wr_urgent;
    logic [PixelBitWidth-1:0]     i_wr_data;
    logic                         o_wr_pop;
    logic                         i_frame_start;
    logic                         i_rd_req;
    logic [PixelBitWidth-1:0]     o_rd_data;
    logic                         o_rd_valid;
    logic                         o_sdram_enable;
    logic                         o_sdram_read;
    logic                         o_sdram_refresh;
    logic [AddressWidthSDRAM-1:0] o_sdram_addr;
    logic [PixelBitWidth-1:0]     o_sdram_data;
    logic                         i_sdram_busy;
    logic                         i_sdram_valid_wr;
    logic                         i_sdram_valid_rd;
    logic [PixelBitWidth-1:0]     i_sdram_data;
    logic                         o_frame_valid;
    logic                         o_frame_drop;
    logic                         o_error;

    modport slave (
        input  i_wr_req, i_wr_urgent, i_wr_data, i_frame_start, i_rd_req,
        input  i_sdram_busy, i_sdram_valid_wr, i_sdram_valid_rd, i_sdram_data,
        output o_wr_pop, o_rd_data, o_rd_valid, o_sdram_enable, o_sdram_read,
        output o_sdram_refresh, o_sdram_addr, o_sdram_data,
        output o_frame_valid, o_frame_drop, o_error
    );

    modport master (
        output i_wr_req, i_wr_urgent, i_wr_data, i_frame_start, i_rd_req,
        output i_sdram_busy, i_sdram_valid_wr, i_sdram_valid_rd, i_sdram_data,
        input  o_wr_pop, o_rd_data, o_rd_valid, o_sdram_enable, o_sdram_read,
        input  o_sdram_refresh, o_sdram_addr, o_sdram_data,
        input  o_frame_valid, o_frame_drop, o_error
    );

endinterface

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag.
module sdram_refresh_timer #(
    parameter int unsigned Interval = 390
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic pending_o
);

    localparam int unsigned CntWidth = $clog2(Interval);
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(Interval - 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic                expire;

    // An expiry while already pending just keeps the flag set; a new expiry beats a clear.
    always_comb begin
        expire = (cnt_q == CntLast);
        cnt_d  = expire ? '0 : cnt_q + CntWidth'(1);
        pend_d = expire | (pend_q & ~clear_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/sdram_frame_arbiter.sv
// Shares one SDRAM controller between the capture writer, the previous-frame reader and
// refresh, and owns the ping-pong frame-buffer addressing.
module sdram_frame_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned FrameWidth        = 640,
    parameter int unsigned FrameHeight       = 480,
    parameter int unsigned PixelBitWidth     = 16,
    parameter int unsigned BurstLength       = 8,
    parameter int unsigned AddressWidthSDRAM = 24,
    parameter int unsigned RefreshInterval   = 390,
    parameter int unsigned TimeoutCycles     = 64
) (
    input logic                  CLK,
    input logic                  RST,
    sdram_frame_arbiter_if.slave bus_io
);

    localparam int unsigned FrameWords = FrameWidth * FrameHeight;
    localparam int unsigned BeatWidth  = (BurstLength > 1) ? $clog2(BurstLength) : 1;
    localparam int unsigned TmoWidth   = $clog2(TimeoutCycles + 1);

    localparam logic [OffsetWidth-1:0] FrameEnd  = OffsetWidth'(FrameWords);
    localparam logic [OffsetWidth-1:0] BurstStep = OffsetWidth'(BurstLength);
    localparam logic [BeatWidth-1:0]   LastBeat  = BeatWidth'(BurstLength - 1);
    localparam logic [TmoWidth-1:0]    TmoLimit  = TmoWidth'(TimeoutCycles);

    state_e                   state_q, state_d;
    logic [OffsetWidth-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
    logic                     wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
    logic                     last_rd_q, last_rd_d;
    logic [BeatWidth-1:0]     beat_q, beat_d;
    logic [TmoWidth-1:0]      tmo_q, tmo_d;
    logic                     frame_pend_q, frame_pend_d;
    logic                     frame_valid_q, frame_valid_d;
    logic                     frame_drop_q, frame_drop_d;
    logic                     error_q, error_d;
    logic [PixelBitWidth-1:0] rd_data_q, rd_data_d;
    logic                     rd_valid_q, rd_valid_d;

    logic refresh_pend, refresh_clr;
    logic wr_ok, rd_ok, strobe, in_data, frame_evt, frame_apply;

    sdram_refresh_timer #(
        .Interval (RefreshInterval)
    ) u_refresh_timer (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clear_i   (refresh_clr),
        .pending_o (refresh_pend)
    );

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        wr_buf_d      = wr_buf_q;
        rd_buf_d      = rd_buf_q;
        last_rd_d     = last_rd_q;
        beat_d        = beat_q;
        tmo_d         = '0;
        frame_valid_d = frame_valid_q;
        frame_drop_d  = 1'b0;
        error_d       = error_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        refresh_clr   = 1'b0;
        strobe        = 1'b0;
        rd_next       = rd_ptr_q + BurstStep;

        bus_io.o_sdram_enable  = 1'b0;
        bus_io.o_sdram_read    = 1'b0;
        bus_io.o_sdram_refresh = 1'b0;
        bus_io.o_sdram_addr    = '0;
        bus_io.o_sdram_data    = '0;
        bus_io.o_wr_pop        = 1'b0;

        wr_ok = bus_io.i_wr_req && (wr_ptr_q < FrameEnd);
        rd_ok = bus_io.i_rd_req && frame_valid_q;

        unique case (state_q)
            StIdle: begin
                // Urgent writes jump the queue; otherwise the last grantee yields.
                if (refresh_pend) begin
                    state_d = StRefresh;
                end else if (wr_ok && (bus_io.i_wr_urgent || !rd_ok || last_rd_q)) begin
                    state_d   = StWrCmd;
                    last_rd_d = 1'b0;
                end else if (rd_ok) begin
                    state_d   = StRdCmd;
                    last_rd_d = 1'b1;
                end
            end
            StRefresh: begin
                if (!bus_io.i_sdram_busy) begin
                    bus_io.o_sdram_refresh = 1'b1;
                    refresh_clr            = 1'b1;
                    state_d                = StIdle;
                end
            end
            StWrCmd: begin
                bus_io.o_sdram_addr = AddressWidthSDRAM'(make_addr(wr_buf_q, wr_ptr_q));
                if (!bus_io.i_sdram_busy) begin
                    bus_io.o_sdram_enable = 1'b1;
                    beat_d                = '0;
                    state_d               = StWrData;
                end
            end
            StWrData: begin
                bus_io.o_sdram_addr = AddressWidthSDRAM'(make_addr(wr_buf_q, wr_ptr_q));
                bus_io.o_sdram_data = bus_io.i_wr_data;
                bus_io.o_wr_pop     = bus_io.i_sdram_valid_wr;
                strobe              = bus_io.i_sdram_valid_wr;
                if (strobe) begin
                    if (beat_q == LastBeat) begin
                        wr_ptr_d = wr_ptr_q + BurstStep;
                        beat_d   = '0;
                        state_d  = StIdle;
                    end else begin
                        beat_d = beat_q + BeatWidth'(1);
                    end
                end
            end
            StRdCmd: begin
                bus_io.o_sdram_read = 1'b1;
                bus_io.o_sdram_addr = AddressWidthSDRAM'(make_addr(rd_buf_q, rd_ptr_q));
                if (!bus_io.i_sdram_busy) begin
                    bus_io.o_sdram_enable = 1'b1;
                    beat_d                = '0;
                    state_d               = StRdData;
                end
            end
            StRdData: begin
                bus_io.o_sdram_read = 1'b1;
                bus_io.o_sdram_addr = AddressWidthSDRAM'(make_addr(rd_buf_q, rd_ptr_q));
                strobe              = bus_io.i_sdram_valid_rd;
                rd_valid_d          = strobe;
                if (strobe) begin
                    rd_data_d = bus_io.i_sdram_data;
                    if (beat_q == LastBeat) begin
                        rd_ptr_d = (rd_next == FrameEnd) ? '0 : rd_next;
                        beat_d   = '0;
                        state_d  = StIdle;
                    end else begin
                        beat_d = beat_q + BeatWidth'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        in_data = (state_q == StWrData) || (state_q == StRdData);
        if (in_data && !strobe) begin
            if (tmo_q == TmoLimit) begin
                error_d = 1'b1;
                beat_d  = '0;
                state_d = StIdle;
            end else begin
                tmo_d = tmo_q + TmoWidth'(1);
            end
        end

        // Frame boundaries wait until no burst is in flight so pointers never move mid-burst.
        frame_evt    = bus_io.i_frame_start || frame_pend_q;
        frame_apply  = frame_evt && ((state_q == StIdle) || (state_q == StRefresh));
        frame_pend_d = frame_evt && !frame_apply;
        if (frame_apply) begin
            wr_ptr_d = '0;
            if (wr_ptr_q == FrameEnd) begin
                wr_buf_d      = rd_buf_q;
                rd_buf_d      = wr_buf_q;
                rd_ptr_d      = '0;
                frame_valid_d = 1'b1;
            end else begin
                frame_drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            wr_buf_q      <= BufIdx0;
            rd_buf_q      <= BufIdx1;
            last_rd_q     <= 1'b1;
            beat_q        <= '0;
            tmo_q         <= '0;
            frame_pend_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_drop_q  <= 1'b0;
            error_q       <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_buf_q      <= wr_buf_d;
            rd_buf_q      <= rd_buf_d;
            last_rd_q     <= last_rd_d;
            beat_q        <= beat_d;
            tmo_q         <= tmo_d;
            frame_pend_q  <= frame_pend_d;
            frame_valid_q <= frame_valid_d;
            frame_drop_q  <= frame_drop_d;
            error_q       <= error_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
        end
    end

    assign bus_io.o_rd_data     = rd_data_q;
    assign bus_io.o_rd_valid    = rd_valid_q;
    assign bus_io.o_frame_valid = frame_valid_q;
    assign bus_io.o_frame_drop  = frame_drop_q;
    assign bus_io.o_error       = error_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Directed bench for sdram_frame_arbiter using a small 8x8 frame (8 bursts per frame).
module tb_sdram_frame_arbiter;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    typedef struct {
        logic wr_req;
        logic rd_req;
        logic urgent;
        logic exp_rd;
        logic exp_bank;
        int   exp_off;
    } vec_t;

    vec_t vec [22];

    sdram_frame_arbiter_if #(.PixelBitWidth(16), .AddressWidthSDRAM(24)) bus ();

    sdram_frame_arbiter #(
        .FrameWidth        (8),
        .FrameHeight       (8),
        .PixelBitWidth     (16),
        .BurstLength       (8),
        .AddressWidthSDRAM (24),
        .RefreshInterval   (390),
        .TimeoutCycles     (64)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic setv(input int i, input logic w, input logic r, input logic u,
                        input logic erd, input logic ebank, input int eoff);
        vec[i].wr_req   = w;
        vec[i].rd_req   = r;
        vec[i].urgent   = u;
        vec[i].exp_rd   = erd;
        vec[i].exp_bank = ebank;
        vec[i].exp_off  = eoff;
    endtask

    task automatic wait_enable(output logic rd, output logic [23:0] addr, output logic ok);
        ok   = 1'b0;
        rd   = 1'b0;
        addr = '0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (bus.o_sdram_enable) begin
                ok   = 1'b1;
                rd   = bus.o_sdram_read;
                addr = bus.o_sdram_addr;
            end
        end
        check("enable_seen", 32'(ok), 32'd1);
    endtask

    task automatic strobe_burst(input logic is_rd, input int n, output int pops, output int errs);
        logic [15:0] d;
        logic [15:0] prev;
        pops = 0;
        errs = 0;
        prev = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (is_rd) begin
                d                     = 16'(32'hA000 + i);
                bus.i_sdram_valid_rd  = 1'b1;
                bus.i_sdram_data      = d;
            end else begin
                d                     = 16'(32'h5000 + i);
                bus.i_sdram_valid_wr  = 1'b1;
                bus.i_wr_data         = d;
            end
            @(negedge clk);
            if (!is_rd) begin
                pops += int'(bus.o_wr_pop);
                if (bus.o_sdram_data !== d) errs++;
            end else if (i > 0 && (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== prev)) begin
                errs++;
            end
            prev = d;
        end
        @(posedge clk);
        #1;
        bus.i_sdram_valid_rd = 1'b0;
        bus.i_sdram_valid_wr = 1'b0;
        if (is_rd && n > 0) begin
            @(negedge clk);
            if (bus.o_rd_valid !== 1'b1 || bus.o_rd_data !== prev) errs++;
        end
    endtask

    task automatic run_vec(input int lo, input int hi);
        logic        rd;
        logic [23:0] addr;
        logic        ok;
        int          pops;
        int          errs;
        for (int k = lo; k <= hi; k++) begin
            bus.i_wr_req    = vec[k].wr_req;
            bus.i_rd_req    = vec[k].rd_req;
            bus.i_wr_urgent = vec[k].urgent;
            wait_enable(rd, addr, ok);
            if (ok) begin
                check($sformatf("v%0d_kind", k), 32'(rd), 32'(vec[k].exp_rd));
                check($sformatf("v%0d_bank", k), 32'(addr[23:22]), 32'({1'b0, vec[k].exp_bank}));
                check($sformatf("v%0d_off", k), 32'(addr[21:0]), 32'(vec[k].exp_off));
                strobe_burst(rd, 8, pops, errs);
                check($sformatf("v%0d_data", k), 32'(errs), 32'd0);
                if (!rd) check($sformatf("v%0d_pops", k), 32'(pops), 32'd8);
            end
        end
    endtask

    task automatic pulse_frame_start(output logic drop_now, output logic drop_next);
        @(posedge clk);
        #1 bus.i_frame_start = 1'b1;
        @(posedge clk);
        #1 bus.i_frame_start = 1'b0;
        @(negedge clk);
        drop_now = bus.o_frame_drop;
        @(negedge clk);
        drop_next = bus.o_frame_drop;
    endtask

    initial begin
        logic        rd;
        logic [23:0] addr;
        logic        ok;
        logic        drop_now;
        logic        drop_next;
        int          pops;
        int          errs;
        int          cyc;
        int          n_ref;
        int          first_ref;
        int          others;
        int          en_cnt;

        n_checks = 0;
        n_pass   = 0;

        setv(0, 1, 0, 0, 0, 0, 0);
        setv(1, 1, 0, 0, 0, 0, 8);
        for (int i = 0; i < 8; i++) setv(2 + i, 1, 0, 0, 0, 0, 8 * i);
        setv(10, 1, 1, 0, 1, 0, 0);
        setv(11, 1, 1, 0, 0, 1, 0);
        setv(12, 1, 1, 0, 1, 0, 8);
        setv(13, 1, 1, 0, 0, 1, 8);
        for (int i = 0; i < 4; i++) setv(14 + i, 1, 1, 1, 0, 1, 16 + 8 * i);
        setv(18, 1, 1, 0, 1, 0, 16);
        setv(19, 1, 1, 0, 0, 1, 48);
        setv(20, 1, 1, 0, 1, 0, 24);
        setv(21, 1, 1, 0, 0, 1, 56);

        rst                  = 1'b1;
        bus.i_wr_req         = 1'b0;
        bus.i_wr_urgent      = 1'b0;
        bus.i_wr_data        = '0;
        bus.i_frame_start    = 1'b0;
        bus.i_rd_req         = 1'b0;
        bus.i_sdram_busy     = 1'b0;
        bus.i_sdram_valid_wr = 1'b0;
        bus.i_sdram_valid_rd = 1'b0;
        bus.i_sdram_data     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle window: one refresh near cycle 390 and nothing else moving.
        n_ref     = 0;
        first_ref = -1;
        others    = 0;
        for (cyc = 1; cyc <= 700; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("rst_frame_valid", 32'(bus.o_frame_valid), 32'd0);
                check("rst_error", 32'(bus.o_error), 32'd0);
                check("rst_refresh", 32'(bus.o_sdram_refresh), 32'd0);
            end
            if (bus.o_sdram_refresh) begin
                n_ref++;
                if (first_ref < 0) first_ref = cyc;
            end
            if (bus.o_sdram_enable || bus.o_sdram_read || bus.o_wr_pop || bus.o_rd_valid ||
                bus.o_frame_valid || bus.o_frame_drop || bus.o_error ||
                bus.o_sdram_addr != 0 || bus.o_sdram_data != 0 || bus.o_rd_data != 0)
                others++;
        end
        check("refresh_count", 32'(n_ref), 32'd1);
        check("refresh_time", 32'(first_ref >= 388 && first_ref <= 396), 32'd1);
        check("idle_outputs", 32'(others), 32'd0);

        // Two bursts then an early frame start: dropped, same bank restarts at 0.
        run_vec(0, 1);
        bus.i_wr_req = 1'b0;
        pulse_frame_start(drop_now, drop_next);
        check("drop_pulse", 32'(drop_now), 32'd1);
        check("drop_one_cycle", 32'(drop_next), 32'd0);
        check("drop_frame_valid", 32'(bus.o_frame_valid), 32'd0);

        // Fill the frame.
        run_vec(2, 9);
        en_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            en_cnt += int'(bus.o_sdram_enable);
        end
        check("full_no_grant", 32'(en_cnt), 32'd0);
        bus.i_wr_req = 1'b0;
        pulse_frame_start(drop_now, drop_next);
        check("swap_no_drop", 32'(drop_now), 32'd0);
        check("swap_frame_valid", 32'(bus.o_frame_valid), 32'd1);

        // Round robin, urgent streak, round robin again.
        run_vec(10, 21);
        bus.i_wr_req    = 1'b0;
        bus.i_rd_req    = 1'b0;
        bus.i_wr_urgent = 1'b0;

        // Short read burst stalls: timeout after more than 64 silent cycles.
        bus.i_rd_req = 1'b1;
        wait_enable(rd, addr, ok);
        bus.i_rd_req = 1'b0;
        check("tmo_kind", 32'(rd), 32'd1);
        check("tmo_off", 32'(addr[21:0]), 32'd32);
        strobe_burst(1'b1, 5, pops, errs);
        n_ref = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            n_ref += int'(bus.o_sdram_refresh);
        end
        check("tmo_not_yet", 32'(bus.o_error), 32'd0);
        check("tmo_still_busy", 32'(bus.o_sdram_read), 32'd1);
        check("no_refresh_mid_burst", 32'(n_ref), 32'd0);
        repeat (10) @(negedge clk);
        check("tmo_error", 32'(bus.o_error), 32'd1);
        check("tmo_idle", 32'(bus.o_sdram_read), 32'd0);

        // Retry reads the same burst address.
        @(posedge clk);
        #1 bus.i_rd_req = 1'b1;
        wait_enable(rd, addr, ok);
        bus.i_rd_req = 1'b0;
        check("retry_off", 32'(addr[21:0]), 32'd32);
        check("retry_bank", 32'(addr[23:22]), 32'd0);
        strobe_burst(1'b1, 8, pops, errs);
        check("retry_data", 32'(errs), 32'd0);
        check("error_sticky", 32'(bus.o_error), 32'd1);

        // Second full frame swaps back; reset in the middle of the next write burst.
        pulse_frame_start(drop_now, drop_next);
        check("swap2_no_drop", 32'(drop_now), 32'd0);
        bus.i_wr_req = 1'b1;
        wait_enable(rd, addr, ok);
        check("swap2_bank", 32'(addr[23:22]), 32'd0);
        check("swap2_off", 32'(addr[21:0]), 32'd0);
        strobe_burst(1'b0, 3, pops, errs);
        bus.i_wr_req         = 1'b0;
        bus.i_sdram_valid_wr = 1'b1;
        rst                  = 1'b1;
        @(posedge clk);
        #1;
        pops   = 0;
        en_cnt = 0;
        for (int c = 0; c < 22; c++) begin
            if (c == 2) rst = 1'b0;
            @(negedge clk);
            pops   += int'(bus.o_wr_pop);
            en_cnt += int'(bus.o_sdram_enable);
            @(posedge clk);
            #1;
        end
        bus.i_sdram_valid_wr = 1'b0;
        check("rst_mid_pops", 32'(pops), 32'd0);
        check("rst_mid_enable", 32'(en_cnt), 32'd0);
        check("rst_mid_frame_valid", 32'(bus.o_frame_valid), 32'd0);
        check("rst_mid_error", 32'(bus.o_error), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
